// File: rtl/card_match_pkg.sv
// Shared types and constants for the card-corner template matching schedulers.
package card_match_pkg;

    localparam int NUM_RANKS = 13;
    localparam int SCORE_W   = 11;
    localparam int RANK_W    = $clog2(NUM_RANKS);

    typedef logic [RANK_W-1:0]  rank_idx_t;
    typedef logic [SCORE_W-1:0] score_t;

    localparam score_t    SCORE_MAX = {SCORE_W{1'b1}};
    localparam rank_idx_t RANK_LAST = rank_idx_t'(NUM_RANKS - 1);

    typedef enum logic [RANK_W-1:0] {
        RANK_A    = 4'd0,
        RANK_2    = 4'd1,
        RANK_3    = 4'd2,
        RANK_4    = 4'd3,
        RANK_5    = 4'd4,
        RANK_6    = 4'd5,
        RANK_7    = 4'd6,
        RANK_8    = 4'd7,
        RANK_9    = 4'd8,
        RANK_10   = 4'd9,
        RANK_J    = 4'd10,
        RANK_Q    = 4'd11,
        RANK_K    = 4'd12,
        RANK_NONE = 4'd15
    } rank_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } sched_state_e;

    function automatic logic is_last_rank(input rank_idx_t k);
        return (k == RANK_LAST);
    endfunction

endpackage

// File: rtl/best_score_tracker.sv
// Running minimum score and its index; strict less-than keeps the lowest index on ties.
// Outputs are look-ahead: they already include this cycle's clear/update.
module best_score_tracker
    import card_match_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               update_i,
    input  logic [SCORE_W-1:0] score_i,
    input  logic [RANK_W-1:0]  idx_i,
    output logic [SCORE_W-1:0] min_o,
    output logic [RANK_W-1:0]  idx_o
);

    score_t    min_q, min_d;
    rank_idx_t idx_q, idx_d;

    // Compare-and-update of the running minimum
    always_comb begin
        min_d = min_q;
        idx_d = idx_q;
        if (clear_i) begin
            min_d = SCORE_MAX;
            idx_d = '0;
        end else if (update_i && (score_i < min_q)) begin
            min_d = score_i;
            idx_d = idx_i;
        end else begin
            min_d = min_q;
            idx_d = idx_q;
        end
    end

    // Running value registers
    always_ff @(posedge clk) begin
        if (rst) begin
            min_q <= SCORE_MAX;
            idx_q <= '0;
        end else begin
            min_q <= min_d;
            idx_q <= idx_d;
        end
    end

    assign min_o = min_d;
    assign idx_o = idx_d;

endmodule

// File: rtl/rank_match_scheduler.sv
// Steps one shared template scorer over all rank kernels and reports the best match.
// Optional REJECT_THRESH_EN: a best score above REJECT_THRESHOLD reports rank "none".
module rank_match_scheduler
    import card_match_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
`ifdef REJECT_THRESH_EN
    ,
    parameter int REJECT_THRESHOLD = 300
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic [RANK_W-1:0]  kernel_sel,
    output logic               score_req,
    input  logic               score_valid,
    input  logic [SCORE_W-1:0] score,
    output logic [RANK_W-1:0]  best_rank,
    output logic [SCORE_W-1:0] best_score,
    output logic               result_valid,
    output logic               timeout_err
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    sched_state_e     state_q, state_d;
    rank_idx_t        kernel_q, kernel_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    score_t           latched_q, latched_d;
    logic             timeout_q, timeout_d;
    rank_idx_t        best_rank_q, best_rank_d;
    score_t           best_score_q, best_score_d;
    logic             busy_q, busy_d;
    logic             score_req_q, score_req_d;
    logic             result_valid_q, result_valid_d;

    logic             trk_clear_s, trk_update_s;
    score_t           trk_min_s;
    rank_idx_t        trk_idx_s;

    best_score_tracker u_tracker (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (trk_clear_s),
        .update_i (trk_update_s),
        .score_i  (latched_q),
        .idx_i    (kernel_q),
        .min_o    (trk_min_s),
        .idx_o    (trk_idx_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? ISSUE : IDLE;
            ISSUE:   state_d = WAIT;
            WAIT: begin
                if (score_valid || (tmo_q == TMO_LAST)) begin
                    state_d = COMPARE;
                end else begin
                    state_d = WAIT;
                end
            end
            COMPARE: state_d = is_last_rank(kernel_q) ? DONE : ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the output flops line up with it
    always_comb begin
        busy_d         = 1'b0;
        score_req_d    = 1'b0;
        result_valid_d = 1'b0;
        case (state_d)
            ISSUE: begin
                busy_d      = 1'b1;
                score_req_d = 1'b1;
            end
            WAIT, COMPARE: busy_d = 1'b1;
            DONE:          result_valid_d = 1'b1;
            default: begin
                busy_d         = 1'b0;
                score_req_d    = 1'b0;
                result_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath: kernel stepping, timeout counting, score latch and final result
    always_comb begin
        kernel_d     = kernel_q;
        tmo_d        = tmo_q;
        latched_d    = latched_q;
        timeout_d    = timeout_q;
        best_rank_d  = best_rank_q;
        best_score_d = best_score_q;
        trk_clear_s  = 1'b0;
        trk_update_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    kernel_d    = '0;
                    timeout_d   = 1'b0;
                    trk_clear_s = 1'b1;
                end else begin
                    kernel_d = kernel_q;
                end
            end
            ISSUE: tmo_d = '0;
            WAIT: begin
                if (score_valid) begin
                    latched_d = score;
                end else if (tmo_q == TMO_LAST) begin
                    latched_d = SCORE_MAX;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
                end
            end
            COMPARE: begin
                trk_update_s = 1'b1;
                if (is_last_rank(kernel_q)) begin
                    // Tracker outputs already include this kernel's compare
                    best_score_d = trk_min_s;
`ifdef REJECT_THRESH_EN
                    if (trk_min_s > SCORE_W'(REJECT_THRESHOLD)) begin
                        best_rank_d = rank_idx_t'(RANK_NONE);
                    end else begin
                        best_rank_d = trk_idx_s;
                    end
`else
                    best_rank_d = trk_idx_s;
`endif
                end else begin
                    kernel_d = kernel_q + 4'd1;
                end
            end
            DONE: kernel_d = kernel_q;
            default: kernel_d = kernel_q;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            kernel_q       <= '0;
            tmo_q          <= '0;
            latched_q      <= SCORE_MAX;
            timeout_q      <= 1'b0;
            best_rank_q    <= rank_idx_t'(RANK_A);
            best_score_q   <= SCORE_MAX;
            busy_q         <= 1'b0;
            score_req_q    <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            kernel_q       <= kernel_d;
            tmo_q          <= tmo_d;
            latched_q      <= latched_d;
            timeout_q      <= timeout_d;
            best_rank_q    <= best_rank_d;
            best_score_q   <= best_score_d;
            busy_q         <= busy_d;
            score_req_q    <= score_req_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign busy         = busy_q;
    assign kernel_sel   = kernel_q;
    assign score_req    = score_req_q;
    assign best_rank    = best_rank_q;
    assign best_score   = best_score_q;
    assign result_valid = result_valid_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_rank_match_scheduler.sv
// Directed bench for rank_match_scheduler with a fixed-latency scorer model.
module tb_rank_match_scheduler;
    import card_match_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               busy;
    logic [RANK_W-1:0]  kernel_sel;
    logic               score_req;
    logic               score_valid;
    logic [SCORE_W-1:0] score;
    logic [RANK_W-1:0]  best_rank;
    logic [SCORE_W-1:0] best_score;
    logic               result_valid;
    logic               timeout_err;

    rank_match_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .kernel_sel   (kernel_sel),
        .score_req    (score_req),
        .score_valid  (score_valid),
        .score        (score),
        .best_rank    (best_rank),
        .best_score   (best_score),
        .result_valid (result_valid),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int sc [NUM_RANKS];
    int lat;
    int silent;
    int repulse_at;
    int stray_at;
    int total  = 0;
    int passed = 0;

    logic               mdl_valid = 1'b0;
    logic [SCORE_W-1:0] mdl_score = '0;
    logic               pend      = 1'b0;
    int                 cnt       = 0;
    logic [RANK_W-1:0]  pk        = '0;
    logic               stray_valid;
    logic [SCORE_W-1:0] stray_score;
    int                 req_cnt   = 0;
    int                 rv_cnt    = 0;

    assign score_valid = mdl_valid | stray_valid;
    assign score       = mdl_valid ? mdl_score : stray_score;

    // Scorer model: answers a request lat cycles after score_req, silent kernel never answers
    always @(posedge clk) begin
        mdl_valid <= 1'b0;
        if (rst) begin
            pend <= 1'b0;
        end else if (score_req) begin
            if (int'(kernel_sel) == silent) begin
                pend <= 1'b0;
            end else if (lat <= 1) begin
                mdl_valid <= 1'b1;
                mdl_score <= SCORE_W'(sc[kernel_sel]);
            end else begin
                pend <= 1'b1;
                cnt  <= lat - 2;
                pk   <= kernel_sel;
            end
        end else if (pend) begin
            if (cnt == 0) begin
                mdl_valid <= 1'b1;
                mdl_score <= SCORE_W'(sc[pk]);
                pend      <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (score_req)    req_cnt <= req_cnt + 1;
        if (result_valid) rv_cnt  <= rv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < NUM_RANKS; i++) sc[i] = v;
    endtask

    // n = cycles from the start cycle to the result_valid cycle (budget if it never came)
    task automatic run_sched(input int budget, output int n);
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            start = (repulse_at != 0 && n == repulse_at) ? 1'b1 : 1'b0;
            if (stray_at != 0 && n == stray_at) begin
                check("stray_in_issue", {31'd0, score_req}, 32'd1);
                stray_valid = 1'b1;
                stray_score = '0;
            end else begin
                stray_valid = 1'b0;
            end
            if (result_valid === 1'b1) break;
        end
    endtask

    int n;
    int req0;
    int rv0;

    initial begin
        rst = 1'b1; start = 1'b0; stray_valid = 1'b0; stray_score = '0;
        lat = 3; silent = -1; repulse_at = 0; stray_at = 0;
        set_all(400);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",         {31'd0, busy},         32'd0);
        check("rst_score_req",    {31'd0, score_req},    32'd0);
        check("rst_result_valid", {31'd0, result_valid}, 32'd0);
        check("rst_timeout",      {31'd0, timeout_err},  32'd0);
        check("rst_kernel_sel",   {28'd0, kernel_sel},   32'd0);
        check("rst_best_rank",    {28'd0, best_rank},    32'd0);
        check("rst_best_score",   {21'd0, best_score},   32'd2047);

        // Single clear winner at kernel 9, L=3
        set_all(400); sc[9] = 50;
        req0 = req_cnt;
        run_sched(200, n);
        check("t1_latency",    n, 32'd66);
        check("t1_best_rank",  {28'd0, best_rank},   32'd9);
        check("t1_best_score", {21'd0, best_score},  32'd50);
        check("t1_busy_done",  {31'd0, busy},        32'd0);
        check("t1_timeout",    {31'd0, timeout_err}, 32'd0);
        check("t1_req_count",  req_cnt - req0,       32'd13);
        // start during the DONE cycle is ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_start_ignored", {31'd0, busy},         32'd0);
        check("rv_one_cycle",       {31'd0, result_valid}, 32'd0);
        repeat (3) @(negedge clk);
        check("hold_busy",       {31'd0, busy},       32'd0);
        check("hold_best_rank",  {28'd0, best_rank},  32'd9);
        check("hold_best_score", {21'd0, best_score}, 32'd50);

        // Tie between kernels 2 and 7: lower index wins
        set_all(400); sc[2] = 10; sc[7] = 10;
        run_sched(200, n);
        check("tie_latency",    n, 32'd66);
        check("tie_best_rank",  {28'd0, best_rank},  32'd2);
        check("tie_best_score", {21'd0, best_score}, 32'd10);
        // start in the cycle right after DONE is accepted
        set_all(300); sc[5] = 20;
        run_sched(200, n);
        check("b2b_latency",    n, 32'd66);
        check("b2b_best_rank",  {28'd0, best_rank},  32'd5);
        check("b2b_best_score", {21'd0, best_score}, 32'd20);

        // start re-pulsed mid-run and a stray score_valid during ISSUE of kernel 1
        set_all(400); sc[9] = 50;
        repeat (2) @(negedge clk);
        repulse_at = 20; stray_at = 6;
        req0 = req_cnt;
        run_sched(200, n);
        repulse_at = 0; stray_at = 0;
        check("rep_latency",    n, 32'd66);
        check("rep_best_rank",  {28'd0, best_rank},  32'd9);
        check("rep_best_score", {21'd0, best_score}, 32'd50);
        check("rep_req_count",  req_cnt - req0,      32'd13);

        // Kernel 4 never answers: 4096-cycle WAIT, timeout sticky
        set_all(200); sc[0] = 150; silent = 4;
        req0 = req_cnt;
        run_sched(5000, n);
        silent = -1;
        check("tmo_latency",    n, 32'd4159);
        check("tmo_flag",       {31'd0, timeout_err}, 32'd1);
        check("tmo_best_rank",  {28'd0, best_rank},   32'd0);
        check("tmo_best_score", {21'd0, best_score},  32'd150);
        check("tmo_req_count",  req_cnt - req0,       32'd13);
        repeat (2) @(negedge clk);
        check("tmo_sticky",     {31'd0, timeout_err}, 32'd1);

        // L=1, winner on the last kernel; timeout_err cleared by the new start
        lat = 1; set_all(500); sc[12] = 7;
        run_sched(200, n);
        check("l1_latency",    n, 32'd40);
        check("l1_best_rank",  {28'd0, best_rank},   32'd12);
        check("l1_best_score", {21'd0, best_score},  32'd7);
        check("l1_timeout",    {31'd0, timeout_err}, 32'd0);
        lat = 3;

        // Reset while kernel 6 is in WAIT
        set_all(400); sc[9] = 50;
        repeat (2) @(negedge clk);
        rv0 = rv_cnt;
        start = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_rst_kernel", {28'd0, kernel_sel}, 32'd6);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_busy",       {31'd0, busy},       32'd0);
        check("mrst_best_score", {21'd0, best_score}, 32'd2047);
        check("mrst_best_rank",  {28'd0, best_rank},  32'd0);
        check("mrst_kernel_sel", {28'd0, kernel_sel}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mrst_no_result", rv_cnt - rv0, 32'd0);
        run_sched(200, n);
        check("post_rst_latency",    n, 32'd66);
        check("post_rst_best_rank",  {28'd0, best_rank},  32'd9);
        check("post_rst_best_score", {21'd0, best_score}, 32'd50);

        // All kernels score 350
        set_all(350);
        run_sched(200, n);
        check("all350_latency",    n, 32'd66);
        check("all350_best_score", {21'd0, best_score}, 32'd350);
`ifdef REJECT_THRESH_EN
        check("all350_rejected", {28'd0, best_rank}, 32'd15);
        sc[11] = 120;
        run_sched(200, n);
        check("rej_k11_rank",  {28'd0, best_rank},  32'd11);
        check("rej_k11_score", {21'd0, best_score}, 32'd120);
`else
        check("all350_argmin", {28'd0, best_rank}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
